// File: rtl/mul_sched.sv
// ---------------------------------------------------------------------------
// mul_sched
//   Shares one pipelined unsigned XLEN x XLEN multiplier between two
//   requesters executing RISC-V M-extension ops (MUL, MULH, MULHSU, MULHU).
//   A round-robin arbiter issues at most one op per cycle. Signed operands
//   are converted to magnitudes before issue, and a LAT-deep tag pipe
//   carries {valid, requester id, high-word select, result sign} alongside
//   the multiplier. When the tag exits, the product sign is restored, the
//   requested word is selected and a registered response goes to the owner.
//
// Parameters
//   XLEN : operand width
//   LAT  : multiplier latency, mul_valid_o to mul_valid_i (>= 1)
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i[1:0]     per-requester request valid
//   req_ready_o[1:0]     per-requester accept (one-hot or zero)
//   req_op_i[3:0]        2-bit op per requester: 00 MUL 01 MULH 10 MULHSU 11 MULHU
//   req_a_i, req_b_i     operands, requester k at [k*XLEN +: XLEN]
//   flush_i              kill all in-flight ops
//   resp_valid_o[1:0]    one-hot result strobe, no backpressure
//   resp_data_o          result word (holds when no strobe)
//   mul_valid_o          issue strobe to the multiplier
//   mul_a_o, mul_b_o     unsigned operand magnitudes
//   mul_flush_o          copy of flush_i
//   mul_valid_i          multiplier result valid
//   mul_prod_i           unsigned 2*XLEN product
//   err_o                sticky: exiting tag valid disagreed with mul_valid_i
//
// Optional build macro MUL_SCHED_PERF_EN adds 32-bit wrapping counters
//   perf_issued_o   : accepted ops
//   perf_conflict_o : cycles with both requesters valid and no flush
// ---------------------------------------------------------------------------
module mul_sched #(
    parameter int XLEN = 32,
    parameter int LAT  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [3:0]        req_op_i,
    input  logic [2*XLEN-1:0] req_a_i,
    input  logic [2*XLEN-1:0] req_b_i,
    input  logic              flush_i,
    output logic [1:0]        resp_valid_o,
    output logic [XLEN-1:0]   resp_data_o,
    output logic              mul_valid_o,
    output logic [XLEN-1:0]   mul_a_o,
    output logic [XLEN-1:0]   mul_b_o,
    output logic              mul_flush_o,
    input  logic              mul_valid_i,
    input  logic [2*XLEN-1:0] mul_prod_i,
    output logic              err_o
`ifdef MUL_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_issued_o,
    output logic [31:0]       perf_conflict_o
`endif
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam int         CW        = $clog2(LAT + 1);

    // Two's-complement magnitude; the most negative value maps onto
    // 2^(XLEN-1), which is exactly its magnitude as an unsigned number.
    function automatic logic [XLEN-1:0] to_mag(input logic [XLEN-1:0] x, input logic is_neg);
        logic signed [XLEN-1:0] xs;
        xs = signed'(x);
        return is_neg ? unsigned'(-xs) : x;
    endfunction

    function automatic logic [2*XLEN-1:0] fix_sign(input logic [2*XLEN-1:0] p, input logic is_neg);
        logic signed [2*XLEN-1:0] ps;
        ps = signed'(p);
        return is_neg ? unsigned'(-ps) : p;
    endfunction

    logic [1:0]      cand;
    logic [1:0]      grant;
    logic            sel;
    logic            issue;
    logic [1:0]      op_s;
    logic [XLEN-1:0] a_s;
    logic [XLEN-1:0] b_s;
    logic            sa;
    logic            sb;

    logic            rr_q, rr_d;
    logic [LAT-1:0]  tag_v_q;
    logic [LAT-1:0]  tag_id_q;
    logic [LAT-1:0]  tag_hi_q;
    logic [LAT-1:0]  tag_neg_q;
    logic [1:0]      resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            err_q, err_d;
    logic [CW-1:0]   mask_q, mask_d;

    logic            ex_v;
    logic            ex_id;
    logic            ex_hi;
    logic            ex_neg;
    logic [2*XLEN-1:0] prod_fix;

    // Arbitration and issue. Reset gates the grant so that every output
    // reads zero while rst_ni is low, even with requests pending.
    assign cand = req_valid_i & ~{2{flush_i}} & {2{rst_ni}};

    always_comb begin
        grant = cand;
        if (cand == 2'b11) begin
            grant = rr_q ? 2'b10 : 2'b01;
        end
    end

    assign sel   = grant[1];
    assign issue = |grant;
    assign op_s  = sel ? req_op_i[3:2] : req_op_i[1:0];
    assign a_s   = sel ? req_a_i[2*XLEN-1:XLEN] : req_a_i[XLEN-1:0];
    assign b_s   = sel ? req_b_i[2*XLEN-1:XLEN] : req_b_i[XLEN-1:0];
    assign sa    = a_s[XLEN-1] & ((op_s == OP_MULH) | (op_s == OP_MULHSU));
    assign sb    = b_s[XLEN-1] & (op_s == OP_MULH);

    assign req_ready_o = grant;
    assign mul_valid_o = issue;
    assign mul_a_o     = issue ? to_mag(a_s, sa) : '0;
    assign mul_b_o     = issue ? to_mag(b_s, sb) : '0;
    assign mul_flush_o = flush_i & rst_ni;

    // Pointer moves to the requester that was not just served.
    assign rr_d = issue ? ~sel : rr_q;

    // Return stage: the tag in the last slot lines up with mul_prod_i.
    assign ex_v     = tag_v_q[LAT-1];
    assign ex_id    = tag_id_q[LAT-1];
    assign ex_hi    = tag_hi_q[LAT-1];
    assign ex_neg   = tag_neg_q[LAT-1];
    assign prod_fix = fix_sign(mul_prod_i, ex_neg);

    always_comb begin
        resp_valid_d = 2'b00;
        resp_data_d  = resp_data_q;
        if (ex_v && !flush_i) begin
            resp_valid_d = ex_id ? 2'b10 : 2'b01;
            resp_data_d  = ex_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

    // Protocol check is masked during a flush and the LAT cycles after it,
    // while the multiplier drains products whose tags were already cleared.
    always_comb begin
        err_d  = err_q;
        mask_d = mask_q;
        if (flush_i) begin
            mask_d = CW'(LAT);
        end else if (mask_q != '0) begin
            mask_d = mask_q - CW'(1);
        end else if (ex_v != mul_valid_i) begin
            err_d = 1'b1;
        end
    end

    // ---- issue -> tag pipe / return register boundary ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q         <= 1'b0;
            tag_v_q      <= '0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
            err_q        <= 1'b0;
            mask_q       <= '0;
        end else begin
            rr_q         <= rr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            err_q        <= err_d;
            mask_q       <= mask_d;
            if (flush_i) begin
                tag_v_q <= '0;
            end else begin
                tag_v_q[0] <= issue;
                for (int i = 1; i < LAT; i++) begin
                    tag_v_q[i] <= tag_v_q[i-1];
                end
            end
        end
    end

    // Tag payload is qualified by tag_v_q and needs no reset.
    always_ff @(posedge clk_i) begin
        tag_id_q[0]  <= sel;
        tag_hi_q[0]  <= (op_s != OP_MUL);
        tag_neg_q[0] <= sa ^ sb;
        for (int i = 1; i < LAT; i++) begin
            tag_id_q[i]  <= tag_id_q[i-1];
            tag_hi_q[i]  <= tag_hi_q[i-1];
            tag_neg_q[i] <= tag_neg_q[i-1];
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign err_o        = err_q;

`ifdef MUL_SCHED_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_conflict_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_issued_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            if (issue) begin
                perf_issued_q <= perf_issued_q + 32'd1;
            end
            if ((req_valid_i == 2'b11) && !flush_i) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
        end
    end

    assign perf_issued_o   = perf_issued_q;
    assign perf_conflict_o = perf_conflict_q;
`endif

endmodule

// File: tb/tb_mul_sched.sv
// ---------------------------------------------------------------------------
// tb_mul_sched
//   Directed testbench for mul_sched with a small LAT-deep multiplier model
//   attached to the mul_* interface. Expected results are hand-computed.
// ---------------------------------------------------------------------------
module tb_mul_sched;

    localparam int XLEN = 32;
    localparam int LAT  = 4;

    localparam logic [1:0] MUL    = 2'b00;
    localparam logic [1:0] MULH   = 2'b01;
    localparam logic [1:0] MULHSU = 2'b10;
    localparam logic [1:0] MULHU  = 2'b11;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [1:0]        req_valid_i = '0;
    logic [1:0]        req_ready_o;
    logic [3:0]        req_op_i = '0;
    logic [2*XLEN-1:0] req_a_i = '0;
    logic [2*XLEN-1:0] req_b_i = '0;
    logic              flush_i = 1'b0;
    logic [1:0]        resp_valid_o;
    logic [XLEN-1:0]   resp_data_o;
    logic              mul_valid_o;
    logic [XLEN-1:0]   mul_a_o;
    logic [XLEN-1:0]   mul_b_o;
    logic              mul_flush_o;
    logic              mul_valid_i;
    logic [2*XLEN-1:0] mul_prod_i;
    logic              err_o;
`ifdef MUL_SCHED_PERF_EN
    logic [31:0]       perf_issued_o;
    logic [31:0]       perf_conflict_o;
`endif

    logic              force_bad = 1'b0;
    int                n_checks = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    mul_sched #(.XLEN(XLEN), .LAT(LAT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .flush_i      (flush_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .mul_valid_o  (mul_valid_o),
        .mul_a_o      (mul_a_o),
        .mul_b_o      (mul_b_o),
        .mul_flush_o  (mul_flush_o),
        .mul_valid_i  (mul_valid_i),
        .mul_prod_i   (mul_prod_i),
        .err_o        (err_o)
`ifdef MUL_SCHED_PERF_EN
        ,
        .perf_issued_o   (perf_issued_o),
        .perf_conflict_o (perf_conflict_o)
`endif
    );

    // Multiplier model: LAT-cycle unsigned product pipe, cleared by flush/reset.
    logic [LAT-1:0]    mv_q;
    logic [2*XLEN-1:0] mp_q [LAT];

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mv_q <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                mv_q[i] <= mv_q[i-1];
                mp_q[i] <= mp_q[i-1];
            end
            mv_q[0] <= mul_valid_o;
            mp_q[0] <= 64'(mul_a_o) * 64'(mul_b_o);
            if (mul_flush_o) mv_q <= '0;
        end
    end

    assign mul_valid_i = mv_q[LAT-1] & ~force_bad;
    assign mul_prod_i  = mp_q[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid_i[k]          = 1'b1;
        req_op_i[2*k +: 2]      = op;
        req_a_i[k*XLEN +: XLEN] = a;
        req_b_i[k*XLEN +: XLEN] = b;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = '0;
        force_bad   = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        req_valid_i = 2'b01;
        #1;
        n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", req_ready_o); end
        n_checks++; if (mul_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mul_valid: got %b want 0", mul_valid_o); end
        tick();
        n_checks++; if (resp_valid_o !== 2'b00) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 00", resp_valid_o); end
        n_checks++; if (resp_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_resp_data: got %h want 0", resp_data_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_o); end
        do_reset();
    endtask

    // One op from one requester; checks issue operands, latency, result, hold.
    task automatic test_single(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ema, input logic [31:0] emb, input logic [31:0] ed, input string nm);
        logic [1:0] ev;
        ev = (k == 1) ? 2'b10 : 2'b01;
        set_req(k, op, a, b);
        #1;
        n_checks++; if (req_ready_o !== ev) begin n_fail++; $display("FAIL %s_ready: got %b want %b", nm, req_ready_o, ev); end
        n_checks++; if (mul_a_o !== ema || mul_b_o !== emb) begin n_fail++; $display("FAIL %s_operands: got %h,%h want %h,%h", nm, mul_a_o, mul_b_o, ema, emb); end
        tick();
        req_valid_i = '0;
        repeat (LAT - 1) tick();
        n_checks++; if (resp_valid_o !== 2'b00) begin n_fail++; $display("FAIL %s_early: got %b want 00", nm, resp_valid_o); end
        tick();
        n_checks++; if (resp_valid_o !== ev) begin n_fail++; $display("FAIL %s_valid: got %b want %b", nm, resp_valid_o, ev); end
        n_checks++; if (resp_data_o !== ed) begin n_fail++; $display("FAIL %s_data: got %h want %h", nm, resp_data_o, ed); end
        tick();
        n_checks++; if (resp_valid_o !== 2'b00 || resp_data_o !== ed) begin n_fail++; $display("FAIL %s_hold: got %b/%h want 00/%h", nm, resp_valid_o, resp_data_o, ed); end
    endtask

    task automatic test_ops();
        test_single(0, MUL,    32'd7,        32'd6,        32'd7,        32'd6,        32'd42,       "mul");
        test_single(1, MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h1,        32'h0,        "mulh_m1");
        test_single(1, MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_m1");
        test_single(1, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
        test_single(0, MULH,   32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
        test_single(0, MUL,    32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h0,        "mul_min");
        test_single(1, MULH,   32'hFFFFFFFD, 32'd5,        32'd3,        32'd5,        32'hFFFFFFFF, "mulh_neg");
        test_single(0, MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, "mul_neg");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  eg [4];
        logic [31:0] ed [4];
        int          na;
        int          nb;
        eg = '{2'b01, 2'b10, 2'b01, 2'b10};
        ed = '{32'd3, 32'd20, 32'd6, 32'd22};
        na = 0;
        nb = 0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_req(0, MUL, (na == 0) ? 32'd1 : 32'd2, 32'd3);
            set_req(1, MUL, (nb == 0) ? 32'd10 : 32'd11, 32'd2);
            #1;
            n_checks++; if (req_ready_o !== eg[c]) begin n_fail++; $display("FAIL b2b_grant%0d: got %b want %b", c, req_ready_o, eg[c]); end
            if (c % 2 == 0) na++; else nb++;
            tick();
        end
        req_valid_i = '0;
        repeat (LAT - 3) tick();
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (resp_valid_o !== eg[c] || resp_data_o !== ed[c]) begin n_fail++; $display("FAIL b2b_resp%0d: got %b/%0d want %b/%0d", c, resp_valid_o, resp_data_o, eg[c], ed[c]); end
            tick();
        end
    endtask

    task automatic test_flush();
        logic seen_resp;
        logic seen_err;
        seen_resp = 1'b0;
        seen_err  = 1'b0;
        do_reset();
        set_req(0, MUL, 32'd5, 32'd5);
        tick();
        set_req(0, MUL, 32'd6, 32'd6);
        tick();
        set_req(0, MUL, 32'd7, 32'd7);
        set_req(1, MUL, 32'd8, 32'd8);
        flush_i = 1'b1;
        #1;
        n_checks++; if (req_ready_o !== 2'b00 || mul_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_grant: got %b/%b want 00/0", req_ready_o, mul_valid_o); end
        n_checks++; if (mul_flush_o !== 1'b1) begin n_fail++; $display("FAIL flush_copy: got %b want 1", mul_flush_o); end
        tick();
        flush_i     = 1'b0;
        req_valid_i = '0;
        for (int i = 0; i < 2 * LAT + 4; i++) begin
            if (resp_valid_o !== 2'b00) seen_resp = 1'b1;
            if (err_o !== 1'b0) seen_err = 1'b1;
            tick();
        end
        n_checks++; if (seen_resp !== 1'b0) begin n_fail++; $display("FAIL flush_no_resp: got %b want 0", seen_resp); end
        n_checks++; if (seen_err !== 1'b0) begin n_fail++; $display("FAIL flush_no_err: got %b want 0", seen_err); end
        // Flush in the very cycle the tag exits suppresses that response.
        set_req(0, MUL, 32'd3, 32'd3);
        tick();
        req_valid_i = '0;
        repeat (LAT - 1) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_checks++; if (resp_valid_o !== 2'b00) begin n_fail++; $display("FAIL flush_exit: got %b want 00", resp_valid_o); end
        repeat (LAT + 2) tick();
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL flush_exit_err: got %b want 0", err_o); end
    endtask

    task automatic test_async_reset();
        logic seen_resp;
        seen_resp = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_req(0, MUL, 32'(i + 1), 32'(i + 1));
            tick();
        end
        n_checks++; if (resp_valid_o !== 2'b01 || resp_data_o !== 32'd1) begin n_fail++; $display("FAIL arst_pre: got %b/%0d want 01/1", resp_valid_o, resp_data_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (resp_valid_o !== 2'b00 || resp_data_o !== 32'h0) begin n_fail++; $display("FAIL arst_resp: got %b/%h want 00/0", resp_valid_o, resp_data_o); end
        n_checks++; if (req_ready_o !== 2'b00 || mul_valid_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl: got %b/%b/%b want 00/0/0", req_ready_o, mul_valid_o, err_o); end
        repeat (2) @(posedge clk);
        #3;
        req_valid_i = '0;
        rst_ni      = 1'b1;
        for (int i = 0; i < 2 * LAT + 2; i++) begin
            tick();
            if (resp_valid_o !== 2'b00) seen_resp = 1'b1;
        end
        n_checks++; if (seen_resp !== 1'b0) begin n_fail++; $display("FAIL arst_no_resp: got %b want 0", seen_resp); end
    endtask

    task automatic test_err();
        do_reset();
        force_bad = 1'b1;
        set_req(0, MUL, 32'd9, 32'd9);
        tick();
        req_valid_i = '0;
        repeat (LAT - 1) tick();
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b want 0", err_o); end
        tick();
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err_o); end
        n_checks++; if (resp_valid_o !== 2'b01 || resp_data_o !== 32'd81) begin n_fail++; $display("FAIL err_resp: got %b/%0d want 01/81", resp_valid_o, resp_data_o); end
        force_bad = 1'b0;
        set_req(1, MUL, 32'd2, 32'd2);
        tick();
        req_valid_i = '0;
        repeat (LAT + 3) tick();
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_o); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
